// File: rtl/dim_pair_sink.sv
// Two-entry FIFO sink for (width, height) pairs; each entry carries its zero-extended sum.
// Optional accepted-pair counter is enabled by defining DIM_PAIR_SINK_STATS_EN.
module dim_pair_sink #(
   parameter int WIDTH  = 10,
   parameter int HEIGHT = 2,
   parameter int CNT_W  = 16,
   localparam int SUM_W = ((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_width,
   input  logic [HEIGHT-1:0] in_height,
   output logic              in_ready,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_width,
   output logic [HEIGHT-1:0] out_height,
   output logic [SUM_W-1:0]  out_sum,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  pair_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]  head_w, tail_w;
   logic [HEIGHT-1:0] head_h, tail_h;
   logic [SUM_W-1:0]  head_s, tail_s;
   logic              push, pop;
   logic              head_from_in, head_from_tail, tail_from_in;

   // Both operands widened before the add, so the carry is never lost.
   function automatic logic [SUM_W-1:0] dim_sum(input logic [WIDTH-1:0]  w,
                                                input logic [HEIGHT-1:0] h);
      return SUM_W'(w) + SUM_W'(h);
   endfunction

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      head_from_in   = 1'b0;
      head_from_tail = 1'b0;
      tail_from_in   = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt    = ONE;
               head_from_in = 1'b1;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_nxt    = FULL;
               tail_from_in = 1'b1;
            end else if (push && pop) begin
               head_from_in = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt      = ONE;
               head_from_tail = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Storage registers: head feeds the outputs, tail holds the second entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_w <= '0;
         head_h <= '0;
         head_s <= '0;
         tail_w <= '0;
         tail_h <= '0;
         tail_s <= '0;
      end else begin
         if (head_from_in) begin
            head_w <= in_width;
            head_h <= in_height;
            head_s <= dim_sum(in_width, in_height);
         end else if (head_from_tail) begin
            head_w <= tail_w;
            head_h <= tail_h;
            head_s <= tail_s;
         end
         if (tail_from_in) begin
            tail_w <= in_width;
            tail_h <= in_height;
            tail_s <= dim_sum(in_width, in_height);
         end
      end
   end

   assign out_width  = head_w;
   assign out_height = head_h;
   assign out_sum    = head_s;

`ifdef DIM_PAIR_SINK_STATS_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)     cnt_q <= '0;
      else if (push) cnt_q <= cnt_q + 1'b1;
   end

   assign pair_count = cnt_q;
`else
   assign pair_count = '0;
`endif

endmodule
